// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stalls, flushes and bubbles for the
// five-stage core, covering load-use, divide latency and memory waits.
module pipe_ctrl #(
   parameter int DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic       d_use_rs,
   input  logic       d_use_rt,
   input  logic       e_memread,
   input  logic [4:0] e_rt,
   input  logic       e_div,
   input  logic       d_branch_taken,
   input  logic       flush,
   input  logic       m_mem,
   input  logic       dmem_ack,
   output logic       en_pc,
   output logic       en_fd,
   output logic       en_de,
   output logic       en_em,
   output logic       en_mw,
   output logic       clr_fd,
   output logic       clr_de,
   output logic       clr_em,
   output logic       clr_mw,
   output logic       div_start,
   output logic       dmem_req
);

   localparam int CW = $clog2(DIV_CYCLES + 1);

   typedef enum logic [1:0] {
      S_RUN,
      S_MEM,
      S_DIV
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_lu;
   logic            w_run;
   logic            w_req;
   logic            w_mst;
   logic            w_dst;
   logic            w_div_go;

   assign w_lu = e_memread && (e_rt != 5'd0) &&
                 ((d_use_rs && (d_rs == e_rt)) ||
                  (d_use_rt && (d_rt == e_rt)));

   // RUN without a flush; flush is only honoured from RUN
   assign w_run    = (r_state == S_RUN) && !flush;
   assign w_req    = (w_run && m_mem) || (r_state == S_MEM);
   assign w_mst    = w_req && !dmem_ack;
   assign w_dst    = (r_state == S_DIV) && (r_cnt != '0);
   assign w_div_go = e_div && !w_mst &&
                     (w_run || (r_state == S_MEM));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      unique case (r_state)
         S_RUN, S_MEM: begin
            if (w_mst) begin
               w_next = S_MEM;
            end else if (w_div_go) begin
               w_next    = S_DIV;
               w_cnt_nxt = CW'(DIV_CYCLES - 1);
            end else if (r_state == S_MEM) begin
               w_next = S_RUN;
            end
         end
         S_DIV: begin
            if (w_dst) w_cnt_nxt = r_cnt - CW'(1);
            else       w_next    = S_RUN;
         end
         default: w_next = S_RUN;
      endcase
   end

   always_comb begin
      en_pc     = 1'b1;
      en_fd     = 1'b1;
      en_de     = 1'b1;
      en_em     = 1'b1;
      en_mw     = 1'b1;
      clr_fd    = 1'b0;
      clr_de    = 1'b0;
      clr_em    = 1'b0;
      clr_mw    = 1'b0;
      div_start = 1'b0;
      dmem_req  = 1'b0;
      // Registers only honour clear while enabled, so enables stay high
      if (!reset) begin
         clr_fd = 1'b1;
         clr_de = 1'b1;
         clr_em = 1'b1;
         clr_mw = 1'b1;
      end else if ((r_state == S_RUN) && flush) begin
         clr_fd = 1'b1;
         clr_de = 1'b1;
         clr_em = 1'b1;
      end else if (w_dst) begin
         en_pc  = 1'b0;
         en_fd  = 1'b0;
         en_de  = 1'b0;
         clr_em = 1'b1;
      end else begin
         dmem_req = w_req;
         if (w_mst) begin
            en_pc  = 1'b0;
            en_fd  = 1'b0;
            en_de  = 1'b0;
            en_em  = 1'b0;
            clr_mw = 1'b1;
         end else if (w_div_go) begin
            div_start = 1'b1;
            en_pc     = 1'b0;
            en_fd     = 1'b0;
            en_de     = 1'b0;
            clr_em    = 1'b1;
         end else if (w_lu) begin
            en_pc  = 1'b0;
            en_fd  = 1'b0;
            clr_de = 1'b1;
         end else if (d_branch_taken) begin
            clr_fd = 1'b1;
         end
      end
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It drives the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It resolves load-use hazards, taken-branch and exception flushes, multi-cycle divide stalls, and data-memory wait states. It sits beside the datapath and owns a small state machine plus a divide-latency counter.

## Interface

- DIV_CYCLES, 32, divider latency in cycles from `div_start` to result valid; legal range ≥2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- d_rs, d_rt  input  5 each  ID-stage source register numbers.
- d_use_rs, d_use_rt  input  1 each  the ID instruction reads rs or rt.
- e_memread  input  1  the EX-stage instruction is a load.
- e_rt  input  5  load destination register in EX.
- e_div  input  1  the EX-stage instruction is div or divu.
- d_branch_taken  input  1  a branch or jump resolved taken in ID.
- flush  input  1  exception flush request.
- m_mem  input  1  the MEM-stage instruction accesses data memory.
- dmem_ack  input  1  data memory completes the access this cycle.
- en_pc, en_fd, en_de, en_em, en_mw  output  1 each  register enables.
- clr_fd, clr_de, clr_em, clr_mw  output  1 each  register clears. A clear only takes effect when the matching enable is high.
- div_start  output  1  one-cycle pulse that launches the divider.
- dmem_req  output  1  data-memory request.

## Operation

- States are RUN, MEM_WAIT and DIV_WAIT. The divide counter `cnt` has width clog2(DIV_CYCLES+1).
- Default outputs: all en_* = 1, all clr_* = 0, div_start = 0, dmem_req = 0.
- Load-use hazard (`lu`) = e_memread & e_rt≠0 & ((d_use_rs & d_rs==e_rt) | (d_use_rt & d_rt==e_rt)).
- Rules in RUN are evaluated in strict priority order; the first match wins.
  1. flush: clr_fd = clr_de = clr_em = 1. The MEM stage still advances.
  2. m_mem: dmem_req = 1. If dmem_ack is high, no stall. If dmem_ack is low:
     - en_pc = en_fd = en_de = en_em = 0.
     - clr_mw = 1, so a bubble enters WB.
     - Next state is MEM_WAIT.
  3. e_div: div_start = 1; en_pc = en_fd = en_de = 0; clr_em = 1; cnt ← DIV_CYCLES-1; next state is DIV_WAIT.
  4. lu: en_pc = en_fd = 0; clr_de = 1.
  5. d_branch_taken: clr_fd = 1.
- MEM_WAIT: dmem_req = 1. Outputs follow the MEM-stall pattern from rule 2 while dmem_ack = 0.
  - On dmem_ack = 1, move to RUN. That cycle applies RUN rules 3–5 only, so a div in EX can move directly to DIV_WAIT.
  - flush is ignored in this state; the requester holds it.
- DIV_WAIT with cnt > 0: cnt decrements; en_pc = en_fd = en_de = 0; clr_em = 1. MEM and WB drain normally.
- DIV_WAIT with cnt == 0: move to RUN. That cycle applies RUN rules 4–5 only, so the divide advances and is never relaunched.
  - m_mem and flush are ignored throughout DIV_WAIT. MEM holds only bubbles after launch.
- Asynchronous reset (reset = 0): state ← RUN, cnt ← 0.
  - Outputs are forced to all en_* = 1, all clr_* = 1, div_start = 0, dmem_req = 0.
  - Enables are forced high because the pipeline registers only honour reset while enabled.
  - Reset asserted mid-DIV_WAIT or mid-MEM_WAIT aborts the operation with no div_start and no residual stall after release.

## Timing

- All outputs are combinational from state, cnt and the current inputs. There are no output registers.
- Load-use costs 1 stall cycle. A taken branch costs 1 flushed slot.
- A divide freezes PC, IF/ID and ID/EX for exactly DIV_CYCLES cycles, starting with the div_start cycle. The div leaves EX on cycle DIV_CYCLES+1.
- A memory access with ack in the same cycle causes 0 stalls. Otherwise the stall is N cycles for an ack in cycle N after the request.
- dmem_req stays high, unbroken, from first assertion until the ack cycle.

## Test plan

- Reset low for 3 cycles: all en = 1, all clr = 1, div_start = 0, dmem_req = 0. Release with idle inputs gives en = 1 and clr = 0 on the next cycle.
- e_memread = 1, e_rt = 5, d_use_rs = 1, d_rs = 5 → exactly one cycle with en_pc = en_fd = 0 and clr_de = 1. Repeat with e_rt = 0 → no stall.
- DIV_CYCLES = 4, e_div pulse → div_start high for 1 cycle, en_de low for 4 cycles. Returns to RUN with no second div_start even though e_div stays high.
- m_mem = 1 with dmem_ack arriving 3 cycles later → dmem_req high for 4 cycles, en_em low for 3 cycles, clr_mw high for 3 cycles.
- flush together with d_branch_taken and lu in RUN → clr_fd = clr_de = clr_em = 1 and en_pc = 1, so flush wins.
- Reset asserted on cycle 2 of DIV_WAIT → state returns to RUN. After release there is no stall, and a fresh e_div relaunches with a full DIV_CYCLES count.
